// File: rtl/speech_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : speech_word_sequencer
// Description : Queues spoken-word codes, resolves each through a lookup ROM
//               and plays them one at a time with a silence gap between words.
//               Optional flush input enabled by defining SEQ_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module speech_word_sequencer #(
  parameter int CODE_W       = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CYCLES   = 2500,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CODE_W-1:0]             word_code,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic [CODE_W-1:0]             lut_index,
  input  logic [23:0]                   lut_start_addr,
  input  logic [23:0]                   lut_end_addr,
  output logic [23:0]                   start_address,
  output logic [23:0]                   end_address,
  output logic                          play_start,
  input  logic                          play_finish,
  input  logic                          clear_error,
`ifdef SEQ_FLUSH_EN
  input  logic                          flush,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          seq_busy,
  output logic                          seq_error
);

  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam int c_cnt_max = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_lvl_w-1:0] c_full      = c_lvl_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_busy_last = c_cnt_w'(BUSY_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit                 c_no_gap    = (GAP_CYCLES == 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_START  = 3'd2,
    ST_BUSY   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CODE_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [CODE_W-1:0]    r_lut_index;
  logic [23:0]          r_start;
  logic [23:0]          r_end;
  logic                 r_play_start;
  logic                 r_error;
  logic                 r_skip_gap;
  logic                 w_flush;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err_set;
  logic                 w_skip_gap;

`ifdef SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_empty    = (r_level == '0);
  assign word_ready = (r_level != c_full);
  assign w_push     = word_valid && word_ready && !w_flush;
  // A flush seen during the current word's playback removes its trailing gap.
  assign w_skip_gap = c_no_gap || r_skip_gap || w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_flush) begin
          w_pop        = 1'b1;
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lut_end_addr < lut_start_addr) begin
          w_err_set    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (!play_finish) begin
          w_state_next = ST_BUSY;
        end else if (r_cnt == c_busy_last) begin
          w_err_set    = 1'b1;
          w_state_next = w_skip_gap ? ST_IDLE : ST_GAP;
        end
      end
      ST_BUSY: begin
        if (play_finish) w_state_next = w_skip_gap ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (w_skip_gap || (r_cnt == c_gap_last)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= word_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_lut_index  <= '0;
      r_start      <= '0;
      r_end        <= '0;
      r_play_start <= 1'b0;
      r_cnt        <= '0;
      r_error      <= 1'b0;
      r_skip_gap   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: ;
        endcase
      end

      if (w_pop) r_lut_index <= r_mem[r_rd_ptr];

      if (r_state == ST_LOOKUP) begin
        r_start <= lut_start_addr;
        r_end   <= lut_end_addr;
      end

      r_play_start <= (w_state_next == ST_START);

      // One counter serves both the START timeout and the GAP length.
      if ((w_state_next == r_state) && ((r_state == ST_START) || (r_state == ST_GAP)))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      if (w_err_set)        r_error <= 1'b1;
      else if (clear_error) r_error <= 1'b0;

      if (r_state == ST_IDLE)                      r_skip_gap <= 1'b0;
      else if (w_flush && (r_state != ST_LOOKUP))  r_skip_gap <= 1'b1;
    end
  end

  assign lut_index     = r_lut_index;
  assign start_address = r_start;
  assign end_address   = r_end;
  assign play_start    = r_play_start;
  assign fifo_level    = r_level;
  assign seq_busy      = (r_state != ST_IDLE) || !w_empty;
  assign seq_error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_speech_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_speech_word_sequencer
// Description : Self-checking bench for speech_word_sequencer with a ROM and
//               playback-controller model; flush steps built with SEQ_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speech_word_sequencer;

  localparam int CODE_W       = 5;
  localparam int FIFO_DEPTH   = 8;
  localparam int GAP_CYCLES   = 6;
  localparam int BUSY_TIMEOUT = 16;
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CODE_W-1:0] word_code = '0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [CODE_W-1:0] lut_index;
  logic [23:0]       lut_start_addr;
  logic [23:0]       lut_end_addr;
  logic [23:0]       start_address;
  logic [23:0]       end_address;
  logic              play_start;
  logic              play_finish;
  logic              clear_error = 1'b0;
  logic [LVL_W-1:0]  fifo_level;
  logic              seq_busy;
  logic              seq_error;
`ifdef SEQ_FLUSH_EN
  logic              flush = 1'b0;
`endif

  speech_word_sequencer #(
    .CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .word_code(word_code), .word_valid(word_valid), .word_ready(word_ready),
    .lut_index(lut_index), .lut_start_addr(lut_start_addr), .lut_end_addr(lut_end_addr),
    .start_address(start_address), .end_address(end_address),
    .play_start(play_start), .play_finish(play_finish),
    .clear_error(clear_error),
`ifdef SEQ_FLUSH_EN
    .flush(flush),
`endif
    .fifo_level(fifo_level), .seq_busy(seq_busy), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] rom_s [32];
  logic [23:0] rom_e [32];
  assign lut_start_addr = rom_s[lut_index];
  assign lut_end_addr   = rom_e[lut_index];

  // Playback controller model: finish drops ctl_delay cycles after a start edge,
  // stays low ctl_len cycles (forever while ctl_hold), never drops if ctl_stuck.
  int ctl_delay = 1, ctl_len = 1, ctl_wait = 0, ctl_left = 0;
  bit ctl_hold = 0, ctl_stuck = 0, ctl_armed = 0, ctl_playing = 0, ctl_prev = 0;
  int fin_rise_cyc = -1;
  always @(negedge clk) begin
    if (reset) begin
      play_finish = 1'b1; ctl_armed = 0; ctl_playing = 0; fin_rise_cyc = -1;
    end else if (ctl_armed) begin
      ctl_wait--;
      if (ctl_wait <= 0) begin
        play_finish = 1'b0; ctl_armed = 0; ctl_playing = 1; ctl_left = ctl_len;
      end
    end else if (ctl_playing) begin
      if (!ctl_hold) begin
        if (ctl_left <= 1) begin
          play_finish = 1'b1; ctl_playing = 0; fin_rise_cyc = cyc;
        end else ctl_left--;
      end
    end else if (play_start && !ctl_prev && !ctl_stuck) begin
      ctl_armed = 1; ctl_wait = ctl_delay;
    end
    ctl_prev = play_start;
  end

  typedef struct { logic [23:0] s; logic [23:0] e; int cyc; int prev_fin; } play_t;
  play_t obs_q[$];
  bit    mon_prev = 0;
  always @(negedge clk) begin
    if (play_start && !mon_prev)
      obs_q.push_back('{s: start_address, e: end_address, cyc: cyc, prev_fin: fin_rise_cyc});
    mon_prev = play_start;
  end

  // Reference model: each accepted word either plays its ROM range or flags an error.
  logic [47:0] exp_q[$];
  bit          exp_err = 0;
  function automatic void add_expected(input int code);
    if (rom_e[code] >= rom_s[code]) exp_q.push_back({rom_s[code], rom_e[code]});
    else exp_err = 1;
  endfunction

  int n_pass = 0, n_checks = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic drain_plays(input string tag, input bit expect_all);
    play_t p;
    logic [47:0] x;
    while (obs_q.size() > 0) begin
      p = obs_q.pop_front();
      check({tag, "_play_expected"}, (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check({tag, "_start_addr"}, p.s, x[47:24]);
        check({tag, "_end_addr"}, p.e, x[23:0]);
        if (p.prev_fin >= 0) check({tag, "_gap"}, (p.cyc - p.prev_fin >= GAP_CYCLES + 2), 1);
      end
    end
    if (expect_all) check({tag, "_all_played"}, exp_q.size(), 0);
  endtask

  task automatic wait_busy_state();
    for (int i = 0; i < 40 && !(obs_q.size() > 0 && !play_start); i++) step();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && seq_busy; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, m, n, code;
    for (int i = 0; i < 32; i++) begin
      rom_s[i] = 24'($urandom_range(16, 32'hFF0000));
      rom_e[i] = rom_s[i] + 24'($urandom_range(0, 4095));
      if (i >= 28) rom_e[i] = rom_s[i] - 24'($urandom_range(1, 15));
    end
    rom_s[3]  = 24'h000100; rom_e[3]  = 24'h0001FF;
    rom_s[30] = 24'h000020; rom_e[30] = 24'h000010;

    repeat (3) step();
    check("rst_level", fifo_level, 0);
    check("rst_ready", word_ready, 1);
    check("rst_play_start", play_start, 0);
    check("rst_start_addr", start_address, 0);
    check("rst_end_addr", end_address, 0);
    check("rst_lut_index", lut_index, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_error", seq_error, 0);
    reset = 1'b0;
    step();

    // Single word latency and gap timing
    ctl_delay = 2; ctl_len = 3;
    word_code = 5'd3; word_valid = 1'b1; add_expected(3); c0 = cyc;
    step(); word_valid = 1'b0;
    check("t1_level_c1", fifo_level, 1);
    step();
    check("t1_level_c2", fifo_level, 0);
    check("t1_lut_index", lut_index, 3);
    check("t1_no_start_c2", play_start, 0);
    step();
    check("t1_start_c3", play_start, 1);
    check("t1_cycle", cyc - c0, 3);
    check("t1_start_address", start_address, 24'h000100);
    check("t1_end_address", end_address, 24'h0001FF);
    step(); check("t1_start_c4", play_start, 1);
    step(); check("t1_start_c5", play_start, 1);
    step(); check("t1_start_low_busy", play_start, 0);
    wait_idle(60);
    check("t1_busy_fall", cyc - fin_rise_cyc, GAP_CYCLES + 1);
    drain_plays("t1", 1);

    // Fill queue while stalled in BUSY
    ctl_hold = 1; ctl_delay = 1; ctl_len = 2;
    word_code = 5'd20; word_valid = 1'b1; add_expected(20);
    step(); word_valid = 1'b0;
    wait_busy_state();
    check("t2_stalled_busy", seq_busy, 1);
    m = 0;
    for (int k = 0; k < 9; k++) begin
      word_code = CODE_W'(k); word_valid = 1'b1;
      check("t2_ready", word_ready, (m != FIFO_DEPTH));
      if (m != FIFO_DEPTH) begin add_expected(k); m++; end
      step();
    end
    word_valid = 1'b0;
    check("t2_level_full", fifo_level, FIFO_DEPTH);
    check("t2_ready_full", word_ready, 0);
    ctl_hold = 0;
    wait_idle(400);
    check("t2_idle", seq_busy, 0);
    drain_plays("t2", 1);

    // Bad ROM range; error set wins over a coincident clear
    exp_err = 0;
    clear_error = 1'b1;
    word_code = 5'd30; word_valid = 1'b1; add_expected(30);
    step(); word_valid = 1'b0;
    step(); step(); clear_error = 1'b0;
    check("t3_error_wins", seq_error, 1);
    check("t3_no_start", play_start, 0);
    word_code = 5'd4; word_valid = 1'b1; add_expected(4);
    step(); word_valid = 1'b0;
    wait_idle(80);
    drain_plays("t3", 1);
    check("t3_error_sticky", seq_error, exp_err);
    clear_error = 1'b1; step(); clear_error = 1'b0;
    check("t3_error_cleared", seq_error, 0);

    // Finish never drops: timeout
    ctl_stuck = 1;
    word_code = 5'd5; word_valid = 1'b1; add_expected(5);
    step(); word_valid = 1'b0;
    for (int i = 0; i < 10 && !play_start; i++) step();
    n = 0;
    while (play_start && n < 40) begin n++; step(); end
    check("t4_start_len", n, BUSY_TIMEOUT);
    check("t4_error", seq_error, 1);
    m = 0;
    while (seq_busy && m < 100) begin m++; step(); end
    check("t4_gap_to_idle", m, GAP_CYCLES);
    drain_plays("t4", 1);
    ctl_stuck = 0;
    clear_error = 1'b1; step(); clear_error = 1'b0;

    // Reset while BUSY with queued words
    ctl_hold = 1; ctl_delay = 1;
    word_code = 5'd6; word_valid = 1'b1; add_expected(6);
    step(); word_valid = 1'b0;
    wait_busy_state();
    for (int k = 7; k < 10; k++) begin
      word_code = CODE_W'(k); word_valid = 1'b1; add_expected(k); step();
    end
    word_valid = 1'b0;
    check("t5_level_before", fifo_level, 3);
    drain_plays("t5", 0);
    reset = 1'b1; #1;
    check("t5_rst_play_start", play_start, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_busy", seq_busy, 0);
    check("t5_rst_ready", word_ready, 1);
    step(); step();
    reset = 1'b0; ctl_hold = 0;
    exp_q.delete();
    repeat (25) step();
    check("t5_no_replay", obs_q.size(), 0);
    check("t5_idle", seq_busy, 0);

    // Reset while play_start is high drops it immediately
    ctl_stuck = 1;
    word_code = 5'd10; word_valid = 1'b1; add_expected(10);
    step(); word_valid = 1'b0;
    for (int i = 0; i < 10 && !play_start; i++) step();
    step();
    check("t5b_start_high", play_start, 1);
    reset = 1'b1; #2;
    check("t5b_async_drop", play_start, 0);
    drain_plays("t5b", 1);
    step(); step();
    reset = 1'b0; ctl_stuck = 0;
    step();

`ifdef SEQ_FLUSH_EN
    // Flush during BUSY: queue emptied, current word ends without a gap
    ctl_hold = 1; ctl_delay = 1; ctl_len = 1;
    for (int k = 0; k < 5; k++) begin
      word_code = CODE_W'(11 + k); word_valid = 1'b1; add_expected(11 + k); step();
    end
    word_valid = 1'b0;
    wait_busy_state();
    check("t6_level_before", fifo_level, 4);
    flush = 1'b1; word_code = 5'd20; word_valid = 1'b1;
    step();
    flush = 1'b0; word_valid = 1'b0;
    check("t6_flushed", fifo_level, 0);
    repeat (4) void'(exp_q.pop_back());
    ctl_hold = 0;
    wait_idle(40);
    check("t6_no_gap", cyc - fin_rise_cyc, 1);
    repeat (20) step();
    drain_plays("t6", 1);
`endif

    // Randomized bursts against the reference model
    for (int r = 0; r < 6; r++) begin
      clear_error = 1'b1; step(); clear_error = 1'b0;
      exp_err = 0;
      ctl_delay = $urandom_range(1, 3);
      ctl_len   = $urandom_range(1, 4);
      n = $urandom_range(1, FIFO_DEPTH);
      for (int k = 0; k < n; k++) begin
        code = $urandom_range(0, 31);
        word_code = CODE_W'(code); word_valid = 1'b1;
        check("rnd_ready", word_ready, 1);
        add_expected(code);
        step();
      end
      word_valid = 1'b0;
      wait_idle(600);
      check("rnd_idle", seq_busy, 0);
      drain_plays("rnd", 1);
      check("rnd_error", seq_error, exp_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/speech_word_sequencer.md
Name: speech_word_sequencer

Overview:
Upstream of the audio playback controller. Buffers a queue of spoken-word codes (digits, operators, "equals", etc.) from the calculator front end. Resolves each code to a flash byte-address range through an external lookup ROM, then drives the playback controller's start_address/end_address/start inputs one word at a time. It waits for the controller's finish handshake and inserts a programmable silence gap between words.

Parameters:
CODE_W, 5, width of a word code (up to 32 distinct words)
FIFO_DEPTH, 8, word queue depth; must be a power of two, minimum 2
GAP_CYCLES, 2500, silence cycles inserted after each word (0 = no gap)
BUSY_TIMEOUT, 16, max cycles to wait for play_finish to fall after play_start rises

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
word_code  in  CODE_W  word to enqueue
word_valid  in  1  word_code valid; push occurs when word_valid && word_ready
word_ready  out  1  queue not full
lut_index  out  CODE_W  registered code presented to the lookup ROM
lut_start_addr  in  24  ROM start byte address for lut_index; combinational, valid in the cycle after lut_index changes
lut_end_addr  in  24  ROM end byte address (inclusive)
start_address  out  24  registered start byte address to the playback controller
end_address  out  24  registered end byte address to the playback controller
play_start  out  1  start level to the playback controller (edge-detected downstream)
play_finish  in  1  playback controller idle indicator
clear_error  in  1  synchronous clear of seq_error
fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
seq_busy  out  1  high when state != IDLE or queue not empty
seq_error  out  1  sticky: timeout or bad range occurred

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state IDLE, queue empty, fifo_level=0, word_ready=1, play_start=0, start_address=0, end_address=0, lut_index=0, seq_busy=0, seq_error=0, all counters 0.
- Queue: synchronous FIFO, circular read/write pointers. word_ready = (fifo_level != FIFO_DEPTH).
  - Push when word_valid && word_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - A push while full is ignored: word_ready=0, no data corruption.
- FSM states: IDLE, LOOKUP, START, BUSY, GAP.
- IDLE: if the queue is not empty, pop the head, register it into lut_index, go to LOOKUP. Otherwise stay.
- LOOKUP (exactly 1 cycle): register lut_start_addr into start_address and lut_end_addr into end_address.
  - If lut_end_addr < lut_start_addr: set seq_error, go to IDLE; the word is skipped with no play_start.
  - Otherwise go to START.
- START: play_start=1 and a timeout counter increments each cycle.
  - play_finish==0 sampled: go to BUSY.
  - Counter reaches BUSY_TIMEOUT: set seq_error, go to GAP.
  - The playback controller always sees a rising start edge at least 1 cycle after the addresses are stable.
- BUSY: play_start=0. When play_finish==1, go to GAP; go directly to IDLE if GAP_CYCLES==0.
- GAP: play_start=0. Count GAP_CYCLES cycles, then go to IDLE. Minimum spacing from a word's finish to the next play_start is GAP_CYCLES+2 cycles.
- start_address/end_address hold their value outside LOOKUP.
- Latency, empty queue with valid push at cycle 0:
  - pop at cycle 1 (fifo_level visible 1 at cycle 1, back to 0 at cycle 2)
  - LOOKUP at cycle 2
  - play_start high from cycle 3
- seq_error is sticky. It is cleared only by reset or clear_error. If clear_error and a new error coincide, the error wins.
- Reset mid-word: everything returns to reset values immediately; queued words are discarded; play_start drops asynchronously.
- play_finish is assumed synchronous to clk (same domain as the playback controller).

Optional Feature:
Macro SEQ_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - A flush pulse empties the queue in the next cycle (fifo_level=0, any same-cycle push is dropped).
  - If in START, BUSY or GAP, the current word finishes normally and the GAP is shortened to 0 cycles.
  - Flush in LOOKUP still completes the current word.
- Not defined: no flush port; the queue drains only by playback.

Test Plan:
1. Reset, push code 3 with ROM[3]=0x000100..0x0001FF, model finish drop 2 cycles after start → start_address=0x000100, end_address=0x0001FF, play_start rises at cycle 3, stays high until finish=0, seq_busy falls GAP_CYCLES+1 cycles after finish rises.
2. Push 9 codes back-to-back with FIFO_DEPTH=8 and the sequencer stalled in BUSY → word_ready=0 after the 8th push, 9th dropped, fifo_level=8, words replayed in push order 0..7.
3. ROM entry with end=0x000010, start=0x000020 → no play_start, seq_error=1, next queued word plays normally; clear_error pulse → seq_error=0.
4. play_finish held at 1 forever → play_start high exactly BUSY_TIMEOUT=16 cycles, seq_error=1, FSM reaches IDLE after the gap.
5. Assert reset during BUSY with 3 words queued → play_start=0, fifo_level=0, state IDLE immediately; no further play_start after release.
6. (SEQ_FLUSH_EN) 5 words queued, flush during BUSY of word 1 → fifo_level=0 next cycle, word 1 completes, no gap, seq_busy=0 after finish rises.
